// File: rtl/veririsc_controller.sv
// VeriRisc eight-phase instruction sequencer: a phase counter plus a sticky halt flag,
// with control strobes decoded combinationally from phase, opcode, zero flag and halt state.
module veririsc_controller #(
   parameter bit          HALT_STICKY = 1'b1,
   parameter int unsigned OPC_W       = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   output logic             sel,
   output logic             rd,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             ld_pc,
   output logic             ld_ac,
   output logic             wr,
   output logic             data_e,
   output logic             halt,
   output logic [2:0]       phase
);

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   typedef enum logic [2:0] {
      OPC_HLT = 3'd0,
      OPC_SKZ = 3'd1,
      OPC_ADD = 3'd2,
      OPC_AND = 3'd3,
      OPC_XOR = 3'd4,
      OPC_LDA = 3'd5,
      OPC_STO = 3'd6,
      OPC_JMP = 3'd7
   } opc_e;

   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;
   opc_e   opc;
   logic   alu_op;

   // Opcode width is fixed at three bits; the cast assumes OPC_W == 3.
   always_comb begin
      opc    = opc_e'(opcode[2:0]);
      alu_op = (opc == OPC_ADD) || (opc == OPC_AND) ||
               (opc == OPC_XOR) || (opc == OPC_LDA);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (!halted_q && en) begin
         if (HALT_STICKY && (phase_q == OP_ADDR) && (opc == OPC_HLT)) begin
            halted_d = 1'b1;
            phase_d  = INST_ADDR;
         end else begin
            phase_d  = phase_e'(phase_q + 3'd1);
         end
      end
   end

   // Reset low masks every strobe so no partial control reaches the datapath.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      if (!rst_n) begin
         halt = 1'b0;
      end else if (halted_q) begin
         halt = 1'b1;
      end else begin
         unique case (phase_q)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opc == OPC_HLT);
            end
            OP_FETCH: begin
               rd = alu_op;
            end
            ALU_OP: begin
               rd     = alu_op;
               inc_pc = (opc == OPC_SKZ) && zero;
               ld_pc  = (opc == OPC_JMP);
               data_e = (opc == OPC_STO);
            end
            STORE: begin
               rd     = alu_op;
               ld_ac  = alu_op;
               ld_pc  = (opc == OPC_JMP);
               wr     = (opc == OPC_STO);
               data_e = (opc == OPC_STO);
            end
            default: begin
               sel = 1'b0;
            end
         endcase
      end
   end

   assign phase = phase_q;

endmodule
